// File: rtl/gf2m_reduce.sv
// Combinational reduction of a (2M-1)-bit GF(2)[x] product modulo x^M + POLY.
// Folds the high coefficients downward, top bit first, using x^M = POLY.
module gf2m_reduce #(
  parameter int unsigned M    = 10,
  parameter logic [M-1:0] POLY = 10'h009
) (
  input  logic [2*M-2:0] i_p,
  output logic [M-1:0]   o_r
);

  localparam int unsigned W = 2 * M - 1;

  logic [W-1:0] w_t;

  // Each fold can only set bits below the one being cleared, so a single
  // top-down pass leaves nothing at or above x^M.
  always_comb begin
    w_t = i_p;
    for (int unsigned k = 0; k < M - 1; k++) begin
      if (w_t[W-1-k]) begin
        w_t[W-1-k]         = 1'b0;
        w_t[W-1-k-M +: M]  = w_t[W-1-k-M +: M] ^ POLY;
      end
    end
    o_r = w_t[M-1:0];
  end

endmodule

// File: rtl/gf2m_mult_seq.sv
// Digit-serial carry-less multiplier over GF(2)[x] with optional reduction
// to GF(2^M); one operation in flight, valid/ready on both sides.
module gf2m_mult_seq #(
  parameter int unsigned  M    = 10,
  parameter int unsigned  D    = 2,
  parameter logic [M-1:0] POLY = 10'h009
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   a,
  input  logic [M-1:0]   b,
  input  logic           mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*M-2:0] c
);

  localparam int unsigned W  = 2 * M - 1;
  localparam int unsigned N  = (M + D - 1) / D;
  localparam int unsigned NB = N * D;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_RED,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [M-1:0]    r_a;
  logic [NB-1:0]   r_b;
  logic            r_mode;
  logic [W-1:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_c;
  logic            r_in_ready;
  logic            r_out_valid;

  logic [D-1:0]    w_digit;
  logic [M-1:0]    w_red;

  function automatic logic [W-1:0] f_clmul(input logic [M-1:0] x,
                                           input logic [D-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < D; j++) begin
      if (d[j]) r = r ^ (W'(x) << j);
    end
    return r;
  endfunction

  assign w_digit = r_b[r_cnt*D +: D];

  gf2m_reduce #(
    .M    (M),
    .POLY (POLY)
  ) u_reduce (
    .i_p (r_acc),
    .o_r (w_red)
  );

  // Horner over digits, MSB first: every intermediate accumulator is a prefix
  // product of degree < 2M-1, so truncating the shift to W bits loses nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_c         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= NB'(b);
            r_mode     <= mode;
            r_acc      <= '0;
            r_cnt      <= CW'(N - 1);
            r_in_ready <= 1'b0;
            r_state    <= S_MUL;
          end
        end
        S_MUL: begin
          r_acc <= (r_acc << D) ^ f_clmul(r_a, w_digit);
          if (r_cnt == '0) begin
            r_state <= S_RED;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RED: begin
          r_c         <= r_mode ? W'(w_red) : r_acc;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign c         = r_c;

endmodule
